clk_div_ctrl: RTL



---
 rtl/clk_div_pkg.sv | 26 ++
 rtl/clk_div_phase.sv | 62 ++++++
 rtl/clk_div_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared types for the runtime-programmable divided-clock controller.
// CLK_DIV_CTRL_DELAY_EN enables the phase-delayed o_clkd output.
package clk_div_pkg;

    localparam int CFG_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_PEND     = 2'd2,
        ST_STOPPING = 2'd3
    } state_t;

    typedef struct packed {
        logic [CFG_W-1:0] n;
        logic [CFG_W-1:0] high;
        logic [CFG_W-1:0] delay;
    } cfg_t;

    // With the delay feature compiled out the delay field is tied to 0,
    // so the delay < n term is always satisfied.
    function automatic logic cfg_valid_chk(input cfg_t c);
        return (c.n >= CFG_W'(2)) && (c.high != '0) && (c.high < c.n) && (c.delay < c.n);
    endfunction

endpackage

// File: rtl/clk_div_phase.sv
// Period counter plus the o_clk / o_clkd comparators of the divided-clock generator.
// CLK_DIV_CTRL_DELAY_EN selects the delayed comparator; otherwise o_clkd copies o_clk.
module clk_div_phase
    import clk_div_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    input  cfg_t act,
    output logic wrap,
    output logic period_tick,
    output logic o_clk,
    output logic o_clkd
);

    logic [CFG_W-1:0] cnt;
    logic             clk_hi;
    logic             clkd_hi;

    assign wrap   = run && (cnt == act.n - CFG_W'(1));
    assign clk_hi = cnt < act.high;

`ifdef CLK_DIV_CTRL_DELAY_EN
    logic [CFG_W:0] shifted;

    // (cnt - delay) mod n without a divider: borrow one period when cnt < delay.
    always_comb begin
        shifted = {1'b0, cnt} - {1'b0, act.delay};
        if (cnt < act.delay) begin
            shifted = shifted + {1'b0, act.n};
        end
    end

    assign clkd_hi = shifted < {1'b0, act.high};
`else
    logic unused_delay;
    assign unused_delay = ^act.delay;
    assign clkd_hi      = clk_hi;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            period_tick <= 1'b0;
            o_clk       <= 1'b0;
            o_clkd      <= 1'b0;
        end else begin
            period_tick <= wrap;
            if (!run || clear) begin
                cnt    <= '0;
                o_clk  <= 1'b0;
                o_clkd <= 1'b0;
            end else begin
                cnt    <= wrap ? '0 : cnt + CFG_W'(1);
                o_clk  <= clk_hi;
                o_clkd <= clkd_hi;
            end
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Runtime-programmable divided-clock controller: FSM, shadow config and validation.
// Define CLK_DIV_CTRL_DELAY_EN to build the delayed o_clkd output and delay registers.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int WIDTH     = CFG_W,
    parameter int DEF_N     = 950,
    parameter int DEF_HIGH  = 475,
    parameter int DEF_DELAY = 240
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_n,
    input  logic [WIDTH-1:0] cfg_high,
    input  logic [WIDTH-1:0] cfg_delay,
    output logic             cfg_err,
    output logic             busy,
    output logic             period_tick,
    output logic             o_clk,
    output logic             o_clkd,
    output state_t           state_dbg
);

    // Handshake: a config transfers on any cycle where cfg_valid && cfg_ready
    // at the rising clk edge; the offer is accepted (valid) or rejected via cfg_err.
    state_t           state;
    logic [WIDTH-1:0] n_a, high_a, n_s, high_s;
    logic             shadow_vld;
    cfg_t             offer, act;
    logic             cfg_ok, hs, load_shadow, wrap, clear;

`ifdef CLK_DIV_CTRL_DELAY_EN
    logic [WIDTH-1:0] delay_a, delay_s;
    assign offer = '{n: cfg_n, high: cfg_high, delay: cfg_delay};
    assign act   = '{n: n_a, high: high_a, delay: delay_a};
`else
    logic unused_cfg_delay;
    assign unused_cfg_delay = ^cfg_delay;
    assign offer = '{n: cfg_n, high: cfg_high, delay: '0};
    assign act   = '{n: n_a, high: high_a, delay: '0};
`endif

    assign cfg_ok      = cfg_valid_chk(offer);
    assign cfg_ready   = (state == ST_IDLE) || (state == ST_RUN);
    assign hs          = cfg_valid && cfg_ready;
    assign load_shadow = (state == ST_RUN) && hs && cfg_ok;
    // A config taken on the final cycle keeps the generator alive for one more period.
    assign clear       = wrap && !en && !load_shadow;
    assign busy        = (state != ST_IDLE);
    assign state_dbg   = state;

    clk_div_phase u_phase (
        .clk         (clk),
        .rst         (rst),
        .run         (busy),
        .clear       (clear),
        .act         (act),
        .wrap        (wrap),
        .period_tick (period_tick),
        .o_clk       (o_clk),
        .o_clkd      (o_clkd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            n_a        <= WIDTH'(DEF_N);
            high_a     <= WIDTH'(DEF_HIGH);
            n_s        <= '0;
            high_s     <= '0;
            shadow_vld <= 1'b0;
            cfg_err    <= 1'b0;
`ifdef CLK_DIV_CTRL_DELAY_EN
            delay_a    <= WIDTH'(DEF_DELAY);
            delay_s    <= '0;
`endif
        end else begin
            cfg_err <= hs && !cfg_ok;
            case (state)
                ST_IDLE: begin
                    if (hs && cfg_ok) begin
                        n_a    <= cfg_n;
                        high_a <= cfg_high;
`ifdef CLK_DIV_CTRL_DELAY_EN
                        delay_a <= cfg_delay;
`endif
                    end
                    if (en) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    if (wrap) begin
                        if (shadow_vld) begin
                            n_a    <= n_s;
                            high_a <= high_s;
`ifdef CLK_DIV_CTRL_DELAY_EN
                            delay_a <= delay_s;
`endif
                        end
                        shadow_vld <= 1'b0;
                        state      <= en ? ST_RUN : ST_IDLE;
                    end else begin
                        state <= !en ? ST_STOPPING : (shadow_vld ? ST_PEND : ST_RUN);
                    end
                    if (load_shadow) begin
                        n_s        <= cfg_n;
                        high_s     <= cfg_high;
`ifdef CLK_DIV_CTRL_DELAY_EN
                        delay_s    <= cfg_delay;
`endif
                        shadow_vld <= 1'b1;
                        state      <= en ? ST_PEND : ST_STOPPING;
                    end
                end
            endcase
        end
    end

endmodule
